// File: rtl/upc_mon_pkg.sv
// Shared types and helpers for the HLS loop/handshake performance monitor.
package upc_mon_pkg;

   localparam int unsigned DEF_CNT_W   = 32;
   localparam int unsigned DEF_STATE_W = 46;
   localparam int unsigned SAT_MAX_W   = 64;

   typedef enum logic [1:0] {
      MOD_IDLE      = 2'd0,
      MOD_BUSY      = 2'd1,
      MOD_WAIT_CONT = 2'd2
   } mod_state_e;

   typedef enum logic {
      LOOP_IDLE = 1'b0,
      LOOP_RUN  = 1'b1
   } loop_state_e;

   // Saturating increment of a w-bit value carried in a 64-bit container (w <= 64).
   function automatic logic [SAT_MAX_W-1:0] sat_inc(input logic [SAT_MAX_W-1:0] v,
                                                     input int unsigned w);
      logic [SAT_MAX_W-1:0] max_v;
      if (w >= SAT_MAX_W) max_v = '1;
      else                max_v = (64'd1 << w) - 64'd1;
      return (v >= max_v) ? max_v : v + 64'd1;
   endfunction

endpackage

// File: rtl/nodf_module_status.sv
// Module-level ap_start/ap_done/ap_continue tracker with transaction, ready and latency counters.
// Ports:
//   clock, reset      : clock, synchronous active-high reset
//   hold              : freeze all state (monitor frozen)
//   ap_start/ap_ready/ap_done/ap_continue : handshake probes
//   now               : free-running cycle count
//   mod_busy          : transaction in flight
//   mod_txn_count     : completed transactions (saturating)
//   mod_ready_count   : cycles with ap_ready high (saturating)
//   mod_last_latency  : start-accept to done cycles of last completed transaction
//   sat_c             : a counter increment was lost to saturation this cycle
module nodf_module_status
   import upc_mon_pkg::*;
#(
   parameter int unsigned CNT_W = DEF_CNT_W
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             hold,
   input  logic             ap_start,
   input  logic             ap_ready,
   input  logic             ap_done,
   input  logic             ap_continue,
   input  logic [CNT_W-1:0] now,
   output logic             mod_busy,
   output logic [CNT_W-1:0] mod_txn_count,
   output logic [CNT_W-1:0] mod_ready_count,
   output logic [CNT_W-1:0] mod_last_latency,
   output logic             sat_c
);

   mod_state_e       state, state_next;
   logic [CNT_W-1:0] start_cycle;
   logic [CNT_W-1:0] pend_latency;
   logic             capture_c;
   logic             complete_c;
   logic             pend_c;
   logic             from_pend_c;
   logic [CNT_W-1:0] latency_c;

   // State register
   always_ff @(posedge clock) begin
      if (reset)      state <= MOD_IDLE;
      else if (!hold) state <= state_next;
   end

   // Next state and per-cycle strobes; a done/continue cycle may also accept a new start
   always_comb begin
      state_next  = state;
      capture_c   = 1'b0;
      complete_c  = 1'b0;
      pend_c      = 1'b0;
      from_pend_c = 1'b0;
      case (state)
         MOD_IDLE: begin
            if (ap_start) begin
               state_next = MOD_BUSY;
               capture_c  = 1'b1;
            end
         end
         MOD_BUSY: begin
            if (ap_done) begin
               if (ap_continue) begin
                  complete_c = 1'b1;
                  if (ap_start) begin
                     capture_c  = 1'b1;
                     state_next = MOD_BUSY;
                  end else begin
                     state_next = MOD_IDLE;
                  end
               end else begin
                  pend_c     = 1'b1;
                  state_next = MOD_WAIT_CONT;
               end
            end
         end
         MOD_WAIT_CONT: begin
            if (ap_continue) begin
               complete_c  = 1'b1;
               from_pend_c = 1'b1;
               if (ap_start) begin
                  capture_c  = 1'b1;
                  state_next = MOD_BUSY;
               end else begin
                  state_next = MOD_IDLE;
               end
            end
         end
         default: state_next = MOD_IDLE;
      endcase
   end

   // Latency is measured to the done cycle, even when continue arrives later
   assign latency_c = from_pend_c ? pend_latency : (now - start_cycle);

   assign sat_c = ~hold & ((complete_c & (mod_txn_count == '1)) |
                           (ap_ready   & (mod_ready_count == '1)));

   // Counters and captured timestamps
   always_ff @(posedge clock) begin
      if (reset) begin
         mod_busy         <= 1'b0;
         mod_txn_count    <= '0;
         mod_ready_count  <= '0;
         mod_last_latency <= '0;
         start_cycle      <= '0;
         pend_latency     <= '0;
      end else if (!hold) begin
         mod_busy <= (state_next != MOD_IDLE);
         if (capture_c) start_cycle  <= now;
         if (pend_c)    pend_latency <= now - start_cycle;
         if (complete_c) begin
            mod_txn_count    <= CNT_W'(sat_inc(64'(mod_txn_count), CNT_W));
            mod_last_latency <= latency_c;
         end
         if (ap_ready) mod_ready_count <= CNT_W'(sat_inc(64'(mod_ready_count), CNT_W));
      end
   end

endmodule

// File: rtl/upc_loop_monitor.sv
// Non-intrusive performance monitor for one HLS block: module handshake plus one pipelined loop.
// Ports:
//   clock, reset                 : clock, synchronous active-high reset
//   ap_*                         : module handshake probes (ap_continue tied 1 when absent)
//   cur_state, *_state           : loop FSM state and reference stage states (full-width compare)
//   *_block / *_enable           : stage subdone block flags and pipeline stage enables
//   loop_start/ready/done/continue : loop-level handshake probes
//   quit_at_end                  : exit-test cycle counts as an iteration when 1
//   finish                       : freeze all counters from the next cycle
//   mod_* outputs                : module status (see nodf_module_status)
//   loop_active, loop_run_count  : loop run in progress / completed runs
//   iter_start_count, iter_end_count, stall_count : loop event counters
//   frozen, overflow             : sticky freeze and saturation flags
module upc_loop_monitor
   import upc_mon_pkg::*;
#(
   parameter int unsigned STATE_W = DEF_STATE_W,
   parameter int unsigned CNT_W   = DEF_CNT_W
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               ap_start,
   input  logic               ap_ready,
   input  logic               ap_done,
   input  logic               ap_continue,
   input  logic [STATE_W-1:0] cur_state,
   input  logic [STATE_W-1:0] iter_start_state,
   input  logic [STATE_W-1:0] iter_end_state,
   input  logic [STATE_W-1:0] quit_state,
   input  logic               iter_start_block,
   input  logic               iter_end_block,
   input  logic               quit_block,
   input  logic               iter_start_enable,
   input  logic               iter_end_enable,
   input  logic               quit_enable,
   input  logic               loop_start,
   input  logic               loop_ready,
   input  logic               loop_done,
   input  logic               loop_continue,
   input  logic               quit_at_end,
   input  logic               finish,
   output logic               mod_busy,
   output logic [CNT_W-1:0]   mod_txn_count,
   output logic [CNT_W-1:0]   mod_ready_count,
   output logic [CNT_W-1:0]   mod_last_latency,
   output logic               loop_active,
   output logic [CNT_W-1:0]   loop_run_count,
   output logic [CNT_W-1:0]   iter_start_count,
   output logic [CNT_W-1:0]   iter_end_count,
   output logic [CNT_W-1:0]   stall_count,
   output logic               frozen,
   output logic               overflow
);

   logic [CNT_W-1:0] cycle;
   loop_state_e      lstate, lstate_next;
   logic             mod_sat_c;
   logic             loop_sat_c;
   logic             start_ev_c, end_ev_c, stall_c, quit_ev_c;
   logic             window_c, exit_probe_c;
   logic             cnt_start_c, cnt_end_c, cnt_stall_c;
   logic             run_done_c;
   logic             unused_c;

   // loop_ready carries no information the counters need
   assign unused_c = loop_ready;

   nodf_module_status #(.CNT_W(CNT_W)) u_mod (
      .clock            (clock),
      .reset            (reset),
      .hold             (frozen),
      .ap_start         (ap_start),
      .ap_ready         (ap_ready),
      .ap_done          (ap_done),
      .ap_continue      (ap_continue),
      .now              (cycle),
      .mod_busy         (mod_busy),
      .mod_txn_count    (mod_txn_count),
      .mod_ready_count  (mod_ready_count),
      .mod_last_latency (mod_last_latency),
      .sat_c            (mod_sat_c)
   );

   // Stage events decoded from the loop FSM probes
   assign start_ev_c = (cur_state == iter_start_state) & iter_start_enable & ~iter_start_block;
   assign end_ev_c   = (cur_state == iter_end_state)   & iter_end_enable   & ~iter_end_block;
   assign stall_c    = (cur_state == iter_start_state) & iter_start_enable &  iter_start_block;
   assign quit_ev_c  = (cur_state == quit_state)       & quit_enable       & ~quit_block;

   // Events count inside a run, including the loop_start cycle itself
   assign window_c     = (lstate == LOOP_RUN) | loop_start;
   // The final exit-test pass through the start stage is not a real iteration
   assign exit_probe_c = ~quit_at_end & loop_done & quit_ev_c;
   assign cnt_start_c  = window_c & start_ev_c & ~exit_probe_c;
   assign cnt_end_c    = window_c & end_ev_c;
   assign cnt_stall_c  = window_c & stall_c;

   // Loop state register
   always_ff @(posedge clock) begin
      if (reset)        lstate <= LOOP_IDLE;
      else if (!frozen) lstate <= lstate_next;
   end

   // Loop next state
   always_comb begin
      lstate_next = lstate;
      run_done_c  = 1'b0;
      case (lstate)
         LOOP_IDLE: if (loop_start) lstate_next = LOOP_RUN;
         LOOP_RUN: begin
            if (loop_done & loop_continue) begin
               lstate_next = LOOP_IDLE;
               run_done_c  = 1'b1;
            end
         end
         default: lstate_next = LOOP_IDLE;
      endcase
   end

   // Overflow flags an increment attempted on an all-ones counter
   assign loop_sat_c = ~frozen & ((run_done_c  & (loop_run_count   == '1)) |
                                  (cnt_start_c & (iter_start_count == '1)) |
                                  (cnt_end_c   & (iter_end_count   == '1)) |
                                  (cnt_stall_c & (stall_count      == '1)));

   // Freeze flag
   always_ff @(posedge clock) begin
      if (reset)       frozen <= 1'b0;
      else if (finish) frozen <= 1'b1;
   end

   // Cycle counter, loop counters and overflow
   always_ff @(posedge clock) begin
      if (reset) begin
         cycle            <= '0;
         loop_active      <= 1'b0;
         loop_run_count   <= '0;
         iter_start_count <= '0;
         iter_end_count   <= '0;
         stall_count      <= '0;
         overflow         <= 1'b0;
      end else if (!frozen) begin
         cycle       <= cycle + CNT_W'(1);
         loop_active <= (lstate_next == LOOP_RUN);
         if (run_done_c)  loop_run_count   <= CNT_W'(sat_inc(64'(loop_run_count), CNT_W));
         if (cnt_start_c) iter_start_count <= CNT_W'(sat_inc(64'(iter_start_count), CNT_W));
         if (cnt_end_c)   iter_end_count   <= CNT_W'(sat_inc(64'(iter_end_count), CNT_W));
         if (cnt_stall_c) stall_count      <= CNT_W'(sat_inc(64'(stall_count), CNT_W));
         overflow <= overflow | mod_sat_c | loop_sat_c;
      end
   end

endmodule

// File: tb/tb_upc_loop_monitor.sv
// Directed bench for upc_loop_monitor: a 32-bit instance for function, a 4-bit instance for saturation.
module tb_upc_loop_monitor;

   logic        clock = 1'b0;
   logic        reset;
   logic        ap_start, ap_ready, ap_done, ap_continue;
   logic [45:0] cur_state, iter_start_state, iter_end_state, quit_state;
   logic        iter_start_block, iter_end_block, quit_block;
   logic        iter_start_enable, iter_end_enable, quit_enable;
   logic        loop_start, loop_ready, loop_done, loop_continue;
   logic        quit_at_end, finish;

   logic        mod_busy, loop_active, frozen, overflow;
   logic [31:0] mod_txn_count, mod_ready_count, mod_last_latency;
   logic [31:0] loop_run_count, iter_start_count, iter_end_count, stall_count;

   logic        s_mod_busy, s_loop_active, s_frozen, s_overflow;
   logic [3:0]  s_mod_txn_count, s_mod_ready_count, s_mod_last_latency;
   logic [3:0]  s_loop_run_count, s_iter_start_count, s_iter_end_count, s_stall_count;

   int unsigned checks   = 0;
   int unsigned failures = 0;

   logic [45:0] st_s, st_e;

   typedef struct {
      logic        st, dn, ct, rd;
      logic        busy;
      int unsigned txn, lat, rdy;
   } mod_vec_t;
   mod_vec_t tbl[14];

   always #5 clock = ~clock;

   upc_loop_monitor dut (
      .clock(clock), .reset(reset),
      .ap_start(ap_start), .ap_ready(ap_ready), .ap_done(ap_done), .ap_continue(ap_continue),
      .cur_state(cur_state), .iter_start_state(iter_start_state),
      .iter_end_state(iter_end_state), .quit_state(quit_state),
      .iter_start_block(iter_start_block), .iter_end_block(iter_end_block), .quit_block(quit_block),
      .iter_start_enable(iter_start_enable), .iter_end_enable(iter_end_enable),
      .quit_enable(quit_enable),
      .loop_start(loop_start), .loop_ready(loop_ready), .loop_done(loop_done),
      .loop_continue(loop_continue), .quit_at_end(quit_at_end), .finish(finish),
      .mod_busy(mod_busy), .mod_txn_count(mod_txn_count), .mod_ready_count(mod_ready_count),
      .mod_last_latency(mod_last_latency), .loop_active(loop_active),
      .loop_run_count(loop_run_count), .iter_start_count(iter_start_count),
      .iter_end_count(iter_end_count), .stall_count(stall_count),
      .frozen(frozen), .overflow(overflow)
   );

   upc_loop_monitor #(.STATE_W(46), .CNT_W(4)) dut_sat (
      .clock(clock), .reset(reset),
      .ap_start(ap_start), .ap_ready(ap_ready), .ap_done(ap_done), .ap_continue(ap_continue),
      .cur_state(cur_state), .iter_start_state(iter_start_state),
      .iter_end_state(iter_end_state), .quit_state(quit_state),
      .iter_start_block(iter_start_block), .iter_end_block(iter_end_block), .quit_block(quit_block),
      .iter_start_enable(iter_start_enable), .iter_end_enable(iter_end_enable),
      .quit_enable(quit_enable),
      .loop_start(loop_start), .loop_ready(loop_ready), .loop_done(loop_done),
      .loop_continue(loop_continue), .quit_at_end(quit_at_end), .finish(finish),
      .mod_busy(s_mod_busy), .mod_txn_count(s_mod_txn_count), .mod_ready_count(s_mod_ready_count),
      .mod_last_latency(s_mod_last_latency), .loop_active(s_loop_active),
      .loop_run_count(s_loop_run_count), .iter_start_count(s_iter_start_count),
      .iter_end_count(s_iter_end_count), .stall_count(s_stall_count),
      .frozen(s_frozen), .overflow(s_overflow)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic idle_inputs();
      ap_start = 1'b0; ap_ready = 1'b0; ap_done = 1'b0; ap_continue = 1'b1;
      cur_state = '0;
      iter_start_block = 1'b0; iter_end_block = 1'b0; quit_block = 1'b0;
      iter_start_enable = 1'b1; iter_end_enable = 1'b1; quit_enable = 1'b1;
      loop_start = 1'b0; loop_ready = 1'b0; loop_done = 1'b0; loop_continue = 1'b1;
      quit_at_end = 1'b0; finish = 1'b0;
   endtask

   task automatic do_reset();
      idle_inputs();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   // One loop run: n_pre start events (first in the loop_start cycle), n_stall blocked
   // cycles, n_post start events, n_end end events, then exit (optionally one held-off exit).
   task automatic run_loop(input logic qae, input int n_pre, input int n_stall,
                           input int n_post, input int n_end, input logic hold_exit);
      quit_at_end = qae;
      cur_state   = st_s;
      loop_start  = 1'b1;
      tick();
      loop_start  = 1'b0;
      for (int i = 1; i < n_pre; i++) tick();
      iter_start_block = 1'b1;
      for (int i = 0; i < n_stall; i++) tick();
      iter_start_block = 1'b0;
      for (int i = 0; i < n_post; i++) tick();
      cur_state = st_e;
      for (int i = 0; i < n_end; i++) tick();
      cur_state = st_s;
      loop_done = 1'b1;
      if (hold_exit) begin
         loop_continue = 1'b0;
         tick();
         chk("loop_active_held_exit", 32'(loop_active), 32'd1);
         loop_continue = 1'b1;
      end
      tick();
      loop_done = 1'b0;
      cur_state = '0;
   endtask

   initial begin
      st_s = 46'd1 << 3;
      st_e = 46'd1 << 40;
      idle_inputs();
      iter_start_state = st_s;
      iter_end_state   = st_e;
      quit_state       = st_s;

      // Reset with probes toggling
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         ap_start   = (i % 2) == 0;
         ap_ready   = (i % 2) == 1;
         ap_done    = 1'b1;
         loop_start = 1'b1;
         loop_done  = (i == 1);
         cur_state  = st_s;
         tick();
      end
      chk("rst_mod_busy",    32'(mod_busy), 32'd0);
      chk("rst_txn",         mod_txn_count, 32'd0);
      chk("rst_ready",       mod_ready_count, 32'd0);
      chk("rst_latency",     mod_last_latency, 32'd0);
      chk("rst_loop_active", 32'(loop_active), 32'd0);
      chk("rst_run_count",   loop_run_count, 32'd0);
      chk("rst_iter_start",  iter_start_count, 32'd0);
      chk("rst_iter_end",    iter_end_count, 32'd0);
      chk("rst_stall",       stall_count, 32'd0);
      chk("rst_frozen",      32'(frozen), 32'd0);
      chk("rst_overflow",    32'(overflow), 32'd0);
      idle_inputs();
      reset = 1'b0;

      // Start at cycle 5, done at cycle 15
      for (int i = 0; i < 5; i++) tick();
      ap_start = 1'b1;
      tick();
      ap_start = 1'b0;
      chk("lat_busy_after_start", 32'(mod_busy), 32'd1);
      for (int i = 0; i < 9; i++) tick();
      ap_done = 1'b1;
      tick();
      ap_done = 1'b0;
      chk("lat_txn",     mod_txn_count, 32'd1);
      chk("lat_latency", mod_last_latency, 32'd10);
      chk("lat_busy",    32'(mod_busy), 32'd0);

      // Handshake vectors: {start, done, continue, ready} -> {busy, txn, latency, ready count}
      tbl[0]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 0, 0, 0};
      tbl[1]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 0, 0, 1};
      tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 0, 0, 1};
      tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 0, 0, 1};
      tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 0, 0, 1};
      tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 0, 0, 1};
      tbl[6]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1, 2, 1};
      tbl[7]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1, 2, 1};
      tbl[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1, 2, 1};
      tbl[9]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 2, 2, 1};
      tbl[10] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2, 2, 2};
      tbl[11] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2, 2, 2};
      tbl[12] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3, 3, 2};
      tbl[13] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 3, 3, 3};
      do_reset();
      for (int r = 0; r < 14; r++) begin
         ap_start    = tbl[r].st;
         ap_done     = tbl[r].dn;
         ap_continue = tbl[r].ct;
         ap_ready    = tbl[r].rd;
         tick();
         chk($sformatf("vec%0d_busy", r),  32'(mod_busy),  32'(tbl[r].busy));
         chk($sformatf("vec%0d_txn", r),   mod_txn_count,    tbl[r].txn);
         chk($sformatf("vec%0d_lat", r),   mod_last_latency, tbl[r].lat);
         chk($sformatf("vec%0d_ready", r), mod_ready_count,  tbl[r].rdy);
      end
      idle_inputs();

      // Loop runs
      do_reset();
      cur_state = st_s;
      tick();
      tick();
      chk("loop_idle_no_count", iter_start_count, 32'd0);
      cur_state = '0;

      run_loop(1'b0, 8, 0, 0, 8, 1'b0);
      chk("run1_iter_start", iter_start_count, 32'd8);
      chk("run1_iter_end",   iter_end_count, 32'd8);
      chk("run1_runs",       loop_run_count, 32'd1);
      chk("run1_inactive",   32'(loop_active), 32'd0);

      run_loop(1'b1, 8, 0, 0, 8, 1'b0);
      chk("run2_iter_start", iter_start_count, 32'd17);
      chk("run2_iter_end",   iter_end_count, 32'd16);
      chk("run2_runs",       loop_run_count, 32'd2);

      run_loop(1'b0, 2, 3, 2, 8, 1'b1);
      chk("run3_iter_start", iter_start_count, 32'd21);
      chk("run3_stall",      stall_count, 32'd3);
      chk("run3_iter_end",   iter_end_count, 32'd24);
      chk("run3_runs",       loop_run_count, 32'd3);
      chk("run3_overflow",   32'(overflow), 32'd0);

      // Saturation and freeze
      do_reset();
      ap_ready = 1'b1;
      for (int i = 0; i < 20; i++) tick();
      ap_ready = 1'b0;
      chk("sat4_ready",     32'(s_mod_ready_count), 32'd15);
      chk("sat4_overflow",  32'(s_overflow), 32'd1);
      chk("sat32_ready",    mod_ready_count, 32'd20);
      chk("sat32_overflow", 32'(overflow), 32'd0);
      finish = 1'b1;
      tick();
      finish = 1'b0;
      chk("frozen32", 32'(frozen), 32'd1);
      chk("frozen4",  32'(s_frozen), 32'd1);
      ap_ready = 1'b1;
      ap_start = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      idle_inputs();
      tick();
      chk("frz4_ready",      32'(s_mod_ready_count), 32'd15);
      chk("frz4_overflow",   32'(s_overflow), 32'd1);
      chk("frz32_ready",     mod_ready_count, 32'd20);
      chk("frz32_busy",      32'(mod_busy), 32'd0);
      chk("frz32_frozen",    32'(frozen), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
